nfc_ecc_buf: RTL and testbench
==============================

// Module: nfc_ecc_buf
// PURPOSE
//  Single-clock, parametrised ECC result buffer between the NFC ECC engine and the memory interface.
//  Encode (nfc_dat_dir=1): packs ECC_DWID-wide parity bytes into DAT_WID-wide words for the mem IF.
//  Decode (nfc_dat_dir=0): queues ECC_AWID-wide error addresses, one per entry, for correction.
//  Adds depth/width generics, full/empty/count status, sticky overflow, partial-word flush
//  and zero-error completion.
// PARAMETERS
//  ECC_DWID  8   ECC encoder data width; DAT_WID must be an integer multiple (RATIO=DAT_WID/ECC_DWID>=1)
//  DAT_WID   16  mem IF data / FIFO entry width
//  ECC_AWID  12  decoder error-address width (<= DAT_WID)
//  DEPTH     16  FIFO entries, power of two
//  AWID      4   log2(DEPTH)
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         asynchronous reset, active low
//  nfc_dat_dir   in   1         1=encode, 0=decode; sampled while IDLE
//  ecc_clr       in   1         sync clear for new sector
//  ecc_fifo_wr   in   1         ECC write strobe
//  ecc_enc_dat   in   ECC_DWID  parity byte (encode)
//  ecc_dec_addr  in   ECC_AWID  error address (decode)
//  ecc_done      in   1         ECC engine finished sector
//  mem_if_rd     in   1         pop head entry
//  mem_enc_dat   out  DAT_WID   head entry, encode mode; 0 in decode mode
//  mem_dec_addr  out  ECC_AWID  head[ECC_AWID-1:0], decode mode; 0 in encode mode
//  ecc_enc_rdy   out  1         1-cycle pulse: encode results complete
//  ecc_dec_rdy   out  1         1-cycle pulse: decode results complete
//  buf_cnt       out  AWID+1    entries held (0..DEPTH)
//  buf_empty     out  1         buf_cnt==0
//  buf_full      out  1         buf_cnt==DEPTH
//  buf_ovf       out  1         sticky: a commit was dropped while full
// BEHAVIOUR
//  Reset: state IDLE; pointers, lane, count, ovf, rdy pulses = 0; buf_empty=1; mem_* = 0.
//  States:
//   IDLE  --ecc_fifo_wr--> FILL
//   IDLE/FILL --ecc_done--> READY
//   READY --(ecc_clr | pop of last entry)--> IDLE
//   READY entered with buf_cnt==0 -> IDLE next cycle.
//  Mode register tracks nfc_dat_dir in IDLE; it is frozen on leaving IDLE, so a mid-sector dir change is ignored.
//  Encode packing: lane counter 0..RATIO-1. Byte n goes to bits [(lane+1)*ECC_DWID-1 : lane*ECC_DWID]
//   (first byte at LSBs). On lane==RATIO-1 the staging word plus the byte commits as one entry; lane wraps to 0.
//  Decode: each write commits {zero-ext, ecc_dec_addr} immediately.
//  ecc_done with lane!=0: partial word commits in that cycle, unfilled lanes = 0.
//   A write in the same cycle as ecc_done is included before the flush.
//  Rdy: ecc_done at cycle T -> ecc_enc_rdy|ecc_dec_rdy (per frozen mode) high exactly at T+1.
//   buf_cnt is final at T+1. ecc_done in IDLE with no writes still pulses rdy (zero-error decode).
//  Writes in READY are ignored, with no flag.
//  Read: show-ahead. Head valid whenever !buf_empty. mem_if_rd pops the same cycle; a pop when empty is ignored.
//  Commit and pop in the same cycle: both take effect and buf_cnt is unchanged. This holds even when full.
//  Commit while full with no pop: entry dropped, buf_ovf=1 until ecc_clr/reset, other state unaffected.
//  Pointers wrap modulo DEPTH. buf_cnt never exceeds DEPTH or underflows.
//  ecc_clr has top priority: pointers/count/lane/ovf = 0, state -> IDLE, no rdy pulse.
//   A coincident write, pop or done is discarded.
//  Async reset mid-operation returns everything to reset values immediately.
// TESTING
//  1 Enc, RATIO=2: write 11,22,33,44,55 then ecc_done
//    -> entries 0x2211,0x4433,0x0055; enc_rdy pulse at T+1; buf_cnt=3; dec_rdy stays 0.
//  2 Dec: addrs 0x005,0x1FF,0xABC then done -> dec_rdy pulse; pops give 0x005,0x1FF,0xABC;
//    mem_enc_dat=0 throughout; state IDLE after 3rd pop.
//  3 Dec: 17 commits with DEPTH=16 -> buf_full=1, buf_ovf=1, buf_cnt=16, head still 1st addr.
//    Commit+pop while full -> cnt=16, ovf unchanged.
//  4 Dec: ecc_done with no writes -> dec_rdy pulse, buf_empty=1, IDLE next cycle.
//    Pop on empty -> no change.
//  5 Enc: 3 bytes written, then ecc_clr coincident with a write
//    -> cnt=0, lane=0, no rdy; next sector packs from lane 0.
//  6 Enc: assert rst_n=0 with 5 entries held -> all outputs at reset values without waiting for clk.
//    Toggle nfc_dat_dir during FILL -> mode unchanged.

Source files
------------

// File: rtl/nfc_ecc_buf.sv
// ECC result buffer between the NFC ECC engine and the memory interface.
// Packs encoder parity bytes into words or queues decoder error addresses.
module nfc_ecc_buf #(
  parameter int ECC_DWID = 8,
  parameter int DAT_WID  = 16,
  parameter int ECC_AWID = 12,
  parameter int DEPTH    = 16,
  parameter int AWID     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nfc_dat_dir,
  input  logic                ecc_clr,
  input  logic                ecc_fifo_wr,
  input  logic [ECC_DWID-1:0] ecc_enc_dat,
  input  logic [ECC_AWID-1:0] ecc_dec_addr,
  input  logic                ecc_done,
  input  logic                mem_if_rd,
  output logic [DAT_WID-1:0]  mem_enc_dat,
  output logic [ECC_AWID-1:0] mem_dec_addr,
  output logic                ecc_enc_rdy,
  output logic                ecc_dec_rdy,
  output logic [AWID:0]       buf_cnt,
  output logic                buf_empty,
  output logic                buf_full,
  output logic                buf_ovf
);

  localparam int RATIO = DAT_WID / ECC_DWID;
  localparam int LWID  = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                mode;
  logic                cur_mode;
  logic [LWID-1:0]     lane;
  logic [LWID-1:0]     lane_nxt;
  logic                last_lane;
  logic [DAT_WID-1:0]  stage;
  logic [DAT_WID-1:0]  stage_ins;
  logic [DAT_WID-1:0]  commit_dat;
  logic [DAT_WID-1:0]  mem [DEPTH];
  logic [AWID-1:0]     wr_ptr;
  logic [AWID-1:0]     rd_ptr;
  logic [AWID:0]       cnt;
  logic                ovf;
  logic                enc_rdy;
  logic                dec_rdy;
  logic                wr_ok;
  logic                done_ok;
  logic                commit;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [DAT_WID-1:0]  head;

  assign full      = (cnt == (AWID+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign last_lane = (lane == LWID'(RATIO-1));
  assign head      = mem[rd_ptr];

  // Commit path: pack encode bytes or forward decode addresses
  always_comb begin
    cur_mode   = (state == S_IDLE) ? nfc_dat_dir : mode;
    wr_ok      = ecc_fifo_wr && (state != S_READY) && !ecc_clr;
    done_ok    = ecc_done && (state != S_READY) && !ecc_clr;
    stage_ins  = stage;
    lane_nxt   = lane;
    commit     = 1'b0;
    commit_dat = stage;
    if (wr_ok && cur_mode) begin
      stage_ins[int'(lane)*ECC_DWID +: ECC_DWID] = ecc_enc_dat;
      lane_nxt = last_lane ? '0 : lane + 1'b1;
    end
    if (cur_mode) begin
      commit     = (wr_ok && last_lane) ||
                   (done_ok && (lane_nxt != '0));
      commit_dat = stage_ins;
    end else begin
      commit     = wr_ok;
      commit_dat = DAT_WID'(ecc_dec_addr);
    end
    if (done_ok) lane_nxt = '0;
    pop  = mem_if_rd && !empty && !ecc_clr;
    push = commit && (!full || pop);
  end

  // Sector sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (done_ok)    state_nxt = S_READY;
        else if (wr_ok) state_nxt = S_FILL;
      end
      S_FILL: begin
        if (done_ok) state_nxt = S_READY;
      end
      S_READY: begin
        if (empty || (cnt == (AWID+1)'(1) && pop))
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (ecc_clr) state_nxt = S_IDLE;
  end

  // State, mode, packing and FIFO bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode    <= 1'b0;
      lane    <= '0;
      stage   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      enc_rdy <= 1'b0;
      dec_rdy <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) mode <= nfc_dat_dir;
      if (ecc_clr) begin
        lane    <= '0;
        stage   <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
        enc_rdy <= 1'b0;
        dec_rdy <= 1'b0;
      end else begin
        lane    <= lane_nxt;
        stage   <= (commit || done_ok) ? '0 : stage_ins;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        cnt     <= cnt + (AWID+1)'(push) - (AWID+1)'(pop);
        if (commit && full && !pop) ovf <= 1'b1;
        enc_rdy <= done_ok && cur_mode;
        dec_rdy <= done_ok && !cur_mode;
      end
    end
  end

  // Storage array, written on accepted commits
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= commit_dat;
  end

  assign mem_enc_dat  = (mode && !empty) ? head : '0;
  assign mem_dec_addr = (!mode && !empty) ? head[ECC_AWID-1:0] : '0;
  assign ecc_enc_rdy  = enc_rdy;
  assign ecc_dec_rdy  = dec_rdy;
  assign buf_cnt      = cnt;
  assign buf_empty    = empty;
  assign buf_full     = full;
  assign buf_ovf      = ovf;

endmodule

// File: tb/tb_nfc_ecc_buf.sv
// Self-checking bench for nfc_ecc_buf.
// Directed sector scenarios followed by random traffic against a queue model.
module tb_nfc_ecc_buf;

  localparam int EW    = 8;
  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 16;
  localparam int RATIO = DW / EW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dir = 1'b0;
  logic          clr = 1'b0;
  logic          wr = 1'b0;
  logic [EW-1:0] enc = '0;
  logic [AW-1:0] addr = '0;
  logic          done = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] mem_enc_dat;
  logic [AW-1:0] mem_dec_addr;
  logic          ecc_enc_rdy;
  logic          ecc_dec_rdy;
  logic [4:0]    buf_cnt;
  logic          buf_empty;
  logic          buf_full;
  logic          buf_ovf;

  nfc_ecc_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .nfc_dat_dir  (dir),
    .ecc_clr      (clr),
    .ecc_fifo_wr  (wr),
    .ecc_enc_dat  (enc),
    .ecc_dec_addr (addr),
    .ecc_done     (done),
    .mem_if_rd    (rd),
    .mem_enc_dat  (mem_enc_dat),
    .mem_dec_addr (mem_dec_addr),
    .ecc_enc_rdy  (ecc_enc_rdy),
    .ecc_dec_rdy  (ecc_dec_rdy),
    .buf_cnt      (buf_cnt),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .buf_ovf      (buf_ovf)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference model: FIFO contents, pending bytes, phase 0 idle/1 fill/2 ready
  int q[$];
  int pend[$];
  int ovf_m;
  int mode_m;
  int phase;
  int erdy_m;
  int drdy_m;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pack_word();
    int w = 0;
    foreach (pend[i]) w += pend[i] * (1 << (i * EW));
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    pend.delete();
    ovf_m  = 0;
    mode_m = 0;
    phase  = 0;
    erdy_m = 0;
    drdy_m = 0;
  endtask

  task automatic model_push(input int w);
    if (q.size() < DEPTH) q.push_back(w);
    else ovf_m = 1;
  endtask

  task automatic model_step();
    int m;
    erdy_m = 0;
    drdy_m = 0;
    m = (phase == 0) ? int'(dir) : mode_m;
    if (phase == 0) mode_m = int'(dir);
    if (clr) begin
      q.delete();
      pend.delete();
      ovf_m = 0;
      phase = 0;
      return;
    end
    if (rd && q.size() > 0) void'(q.pop_front());
    if (phase != 2) begin
      if (wr) begin
        if (m != 0) begin
          pend.push_back(int'(enc));
          if (pend.size() == RATIO) begin
            model_push(pack_word());
            pend.delete();
          end
        end else begin
          model_push(int'(addr));
        end
        if (phase == 0) phase = 1;
      end
      if (done) begin
        if (pend.size() > 0) model_push(pack_word());
        pend.delete();
        erdy_m = (m != 0);
        drdy_m = (m == 0);
        phase  = 2;
      end
    end else if (q.size() == 0) begin
      phase = 0;
    end
  endtask

  task automatic check_all();
    int hd;
    int ee;
    int ed;
    hd = (q.size() > 0) ? q[0] : 0;
    ee = (mode_m != 0 && q.size() > 0) ? hd : 0;
    ed = (mode_m == 0 && q.size() > 0) ? (hd & 32'hFFF) : 0;
    chk("enc_dat", 32'(mem_enc_dat), 32'(ee));
    chk("dec_addr", 32'(mem_dec_addr), 32'(ed));
    chk("enc_rdy", 32'(ecc_enc_rdy), 32'(erdy_m));
    chk("dec_rdy", 32'(ecc_dec_rdy), 32'(drdy_m));
    chk("cnt", 32'(buf_cnt), 32'(q.size()));
    chk("empty", 32'(buf_empty), 32'(q.size() == 0));
    chk("full", 32'(buf_full), 32'(q.size() == DEPTH));
    chk("ovf", 32'(buf_ovf), 32'(ovf_m));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    wr   = 1'b0;
    done = 1'b0;
    rd   = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic wr_enc(input logic [7:0] b);
    wr  = 1'b1;
    enc = b;
    cyc();
  endtask

  task automatic wr_dec(input logic [11:0] a);
    wr   = 1'b1;
    addr = a;
    cyc();
  endtask

  initial begin
    logic [7:0] bytes1 [5];
    logic [11:0] addrs2 [3];
    logic [15:0] exp1 [3];
    bytes1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    addrs2 = '{12'h005, 12'h1FF, 12'hABC};
    exp1   = '{16'h2211, 16'h4433, 16'h0055};
    model_reset();
    #12;
    chk("rst_cnt", 32'(buf_cnt), 0);
    chk("rst_empty", 32'(buf_empty), 1);
    chk("rst_enc", 32'(mem_enc_dat), 0);
    chk("rst_rdy", 32'({ecc_enc_rdy, ecc_dec_rdy, buf_ovf}), 0);
    rst_n = 1'b1;

    // 1: encode packing with partial flush
    dir = 1'b1;
    cyc();
    foreach (bytes1[i]) wr_enc(bytes1[i]);
    done = 1'b1;
    cyc();
    chk("t1_rdy", 32'({ecc_enc_rdy, ecc_dec_rdy}), 32'h2);
    chk("t1_cnt", 32'(buf_cnt), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_head", 32'(mem_enc_dat), 32'(exp1[i]));
      rd = 1'b1;
      cyc();
    end
    cyc();

    // 2: decode addresses
    dir = 1'b0;
    cyc();
    foreach (addrs2[i]) wr_dec(addrs2[i]);
    done = 1'b1;
    cyc();
    chk("t2_rdy", 32'({ecc_enc_rdy, ecc_dec_rdy}), 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_head", 32'(mem_dec_addr), 32'(addrs2[i]));
      chk("t2_enc0", 32'(mem_enc_dat), 0);
      rd = 1'b1;
      cyc();
    end
    chk("t2_empty", 32'(buf_empty), 1);
    wr_dec(12'h777);
    chk("t2_idle_wr", 32'(buf_cnt), 1);
    clr = 1'b1;
    cyc();

    // 3: overflow in decode
    for (int i = 0; i < 17; i++) wr_dec(12'(i + 1));
    chk("t3_full", 32'(buf_full), 1);
    chk("t3_ovf", 32'(buf_ovf), 1);
    chk("t3_cnt", 32'(buf_cnt), 16);
    chk("t3_head", 32'(mem_dec_addr), 1);
    wr = 1'b1;
    rd = 1'b1;
    addr = 12'h321;
    cyc();
    chk("t3_cnt2", 32'(buf_cnt), 16);
    chk("t3_head2", 32'(mem_dec_addr), 2);
    clr = 1'b1;
    cyc();

    // 4: zero-error decode completion
    done = 1'b1;
    cyc();
    chk("t4_rdy", 32'(ecc_dec_rdy), 1);
    rd = 1'b1;
    cyc();
    chk("t4_cnt", 32'(buf_cnt), 0);
    wr_dec(12'h0AA);
    chk("t4_idle", 32'(buf_cnt), 1);
    clr = 1'b1;
    cyc();

    // 5: clear mid-sector with coincident write
    dir = 1'b1;
    cyc();
    wr_enc(8'h01);
    wr_enc(8'h02);
    wr_enc(8'h03);
    clr = 1'b1;
    wr_enc(8'h04);
    chk("t5_cnt", 32'(buf_cnt), 0);
    wr_enc(8'hAA);
    wr_enc(8'hBB);
    chk("t5_head", 32'(mem_enc_dat), 32'hBBAA);
    clr = 1'b1;
    cyc();

    // 6: dir toggle during fill, then async reset
    cyc();
    wr_enc(8'hC1);
    dir = 1'b0;
    for (int i = 0; i < 9; i++) wr_enc(8'(8'hC2 + i));
    chk("t6_head", 32'(mem_enc_dat), 32'hC2C1);
    chk("t6_cnt", 32'(buf_cnt), 5);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_cnt0", 32'(buf_cnt), 0);
    chk("t6_empty", 32'(buf_empty), 1);
    chk("t6_enc0", 32'(mem_enc_dat), 0);
    chk("t6_dec0", 32'(mem_dec_addr), 0);
    #1;
    rst_n = 1'b1;
    cyc();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      wr   = ($urandom_range(0, 2) != 0);
      rd   = ($urandom_range(0, 3) == 0);
      done = ($urandom_range(0, 14) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      enc  = 8'($urandom);
      addr = 12'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
